dlx_regfile: RTL and testbench

- Dual-bank architectural register file: 32x32 integer bank and 32x32 floating-point bank.
- Sits directly upstream of the execute stage (ALU/FPU). Drives busA/busB from the integer bank and fbusA/fbusB from the FP bank.
- Accepts writeback of execute results and a dedicated link write for jump-and-link.
- Reads are combinational. Writes are registered on the rising clock edge.

---
 rtl/dlx_regfile.sv | 118 +++++++++++
 tb/tb_dlx_regfile.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_regfile.sv
// rtl/dlx_regfile.sv - dual-bank (integer/FP) DLX register file with link port and write counter
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module dlx_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_we,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_data,
  input  logic [ADDR_W-1:0] frs1_addr,
  input  logic [ADDR_W-1:0] frs2_addr,
  input  logic [ADDR_W-1:0] frd_addr,
  input  logic              frd_we,
  input  logic [DATA_W-1:0] frd_data,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] fbusA,
  output logic [DATA_W-1:0] fbusB,
  output logic [15:0]       wr_count
);

  localparam int Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LinkIdx = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] intReg [Depth];
  logic [DATA_W-1:0] fpReg  [Depth];

  logic        linkCommit;
  logic        rdCommit;
  logic        frdCommit;
  logic [1:0]  numWrites;
  logic [16:0] countSum;
  logic [15:0] countNext;

  // Link has priority over rd on the link register; r0 writes are discarded.
  assign linkCommit = link_we;
  assign rdCommit   = rd_we && (rd_addr != '0) && !(link_we && (rd_addr == LinkIdx));
  assign frdCommit  = frd_we;

  assign numWrites = {1'b0, linkCommit} + {1'b0, rdCommit} + {1'b0, frdCommit};
  assign countSum  = {1'b0, wr_count} + {15'b0, numWrites};
  assign countNext = countSum[16] ? 16'hFFFF : countSum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        intReg[i] <= '0;
      end
    end else begin
      if (linkCommit) begin
        intReg[LinkIdx] <= link_data;
      end
      if (rdCommit) begin
        intReg[rd_addr] <= rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        fpReg[i] <= '0;
      end
    end else if (frdCommit) begin
      fpReg[frd_addr] <= frd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else begin
      wr_count <= countNext;
    end
  end

  function automatic logic [DATA_W-1:0] intRead(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = intReg[addr];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && linkCommit && (addr == LinkIdx)) begin
      value = link_data;
    end else if (rst_n && rdCommit && (addr == rd_addr)) begin
      value = rd_data;
    end
`endif
    if (addr == '0) begin
      value = '0;
    end
    return value;
  endfunction

  function automatic logic [DATA_W-1:0] fpRead(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = fpReg[addr];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && frdCommit && (addr == frd_addr)) begin
      value = frd_data;
    end
`endif
    return value;
  endfunction

  always_comb begin
    busA  = intRead(rs1_addr);
    busB  = intRead(rs2_addr);
    fbusA = fpRead(frs1_addr);
    fbusB = fpRead(frs2_addr);
  end

endmodule

// File: tb/tb_dlx_regfile.sv
// tb/tb_dlx_regfile.sv - self-checking bench for dlx_regfile: vector table, corner sequences, random vs model
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when defined.
module tb_dlx_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, frs1_addr, frs2_addr, frd_addr;
  logic        rd_we, link_we, frd_we;
  logic [31:0] rd_data, link_data, frd_data;
  logic [31:0] busA, busB, fbusA, fbusB;
  logic [15:0] wr_count;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  dlx_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_we(rd_we), .rd_data(rd_data),
    .link_we(link_we), .link_data(link_data),
    .frs1_addr(frs1_addr), .frs2_addr(frs2_addr),
    .frd_addr(frd_addr), .frd_we(frd_we), .frd_data(frd_data),
    .busA(busA), .busB(busB), .fbusA(fbusA), .fbusB(fbusB),
    .wr_count(wr_count)
  );

  typedef struct {
    logic        rdWe;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic        linkWe;
    logic [31:0] linkData;
    logic        frdWe;
    logic [4:0]  frdAddr;
    logic [31:0] frdData;
    logic [4:0]  rs1, rs2, frs1, frs2;
    logic [31:0] expA, expB, expFa, expFb;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs[4];

  // Plain arrays standing for the architectural state.
  logic [31:0] mInt [32];
  logic [31:0] mFp  [32];
  int          mCnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_we = 1'b0; link_we = 1'b0; frd_we = 1'b0;
    rd_addr = '0; rd_data = '0; link_data = '0; frd_addr = '0; frd_data = '0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mInt[i] = '0;
      mFp[i]  = '0;
    end
    mCnt = 0;
  endtask

  task automatic asyncReset();
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    check("async_reset_cnt", {16'b0, wr_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] nInt [32];
    logic [31:0] nFp  [32];
    int writes;
    idle();
    rs1_addr = 5; rs2_addr = 0; frs1_addr = 0; frs2_addr = 0;
    rst_n = 1'b0;

    // Writes attempted during reset must be ignored.
    rd_we = 1'b1; rd_addr = 5; rd_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busA", busA, 32'h0);
    check("reset_cnt", {16'b0, wr_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle();
    #1;
    check("release_busA", busA, 32'hDEADBEEF);
    check("release_cnt", {16'b0, wr_count}, 32'h1);

    vecs[0] = '{1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 5, 0, 1,
                32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 16'd1};
    vecs[1] = '{1, 31, 32'hFFFF0000, 1, 32'h104, 0, 0, 0, 5, 31, 0, 1,
                32'hDEADBEEF, 32'h104, 32'h0, 32'h0, 16'd2};
    vecs[2] = '{1, 3, 32'h7, 1, 32'h8, 1, 0, 32'h3F800000, 3, 31, 0, 1,
                32'h7, 32'h8, 32'h3F800000, 32'h0, 16'd5};
    vecs[3] = '{1, 7, 32'h1, 0, 0, 1, 31, 32'hCAFE0001, 7, 0, 31, 0,
                32'h1, 32'h0, 32'hCAFE0001, 32'h3F800000, 16'd7};

    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      rd_we = vecs[v].rdWe; rd_addr = vecs[v].rdAddr; rd_data = vecs[v].rdData;
      link_we = vecs[v].linkWe; link_data = vecs[v].linkData;
      frd_we = vecs[v].frdWe; frd_addr = vecs[v].frdAddr; frd_data = vecs[v].frdData;
      rs1_addr = vecs[v].rs1; rs2_addr = vecs[v].rs2;
      frs1_addr = vecs[v].frs1; frs2_addr = vecs[v].frs2;
      @(posedge clk); #1;
      idle();
      #1;
      check($sformatf("vec%0d_busA", v), busA, vecs[v].expA);
      check($sformatf("vec%0d_busB", v), busB, vecs[v].expB);
      check($sformatf("vec%0d_fbusA", v), fbusA, vecs[v].expFa);
      check($sformatf("vec%0d_fbusB", v), fbusB, vecs[v].expFb);
      check($sformatf("vec%0d_cnt", v), {16'b0, wr_count}, {16'b0, vecs[v].expCnt});
    end

    // Read and write of r7 in the same cycle.
    @(negedge clk);
    rd_we = 1'b1; rd_addr = 7; rd_data = 32'h2; rs1_addr = 7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_pre", busA, 32'h2);
`else
    check("same_cycle_pre", busA, 32'h1);
`endif
    @(posedge clk); #1;
    idle();
    #1;
    check("same_cycle_post", busA, 32'h2);
    check("same_cycle_cnt", {16'b0, wr_count}, 32'd8);

    // Randomised traffic against the model.
    asyncReset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rd_we = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? 5'(($urandom_range(0, 1) == 0) ? 0 : 31) : 5'($urandom_range(0, 31));
      rd_data = $urandom;
      link_we = ($urandom_range(0, 3) == 0);
      link_data = $urandom;
      frd_we = 1'($urandom_range(0, 1));
      frd_addr = 5'($urandom_range(0, 31));
      frd_data = $urandom;
      rs1_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      frs1_addr = ($urandom_range(0, 2) == 0) ? frd_addr : 5'($urandom_range(0, 31));
      frs2_addr = 5'($urandom_range(0, 31));

      // Post-edge state from the architectural rules.
      nInt = mInt;
      nFp = mFp;
      writes = 0;
      if (rd_we && rd_addr != 0) begin
        nInt[rd_addr] = rd_data;
        writes++;
      end
      if (link_we) begin
        if (rd_we && rd_addr == 31) writes--;
        nInt[31] = link_data;
        writes++;
      end
      if (frd_we) begin
        nFp[frd_addr] = frd_data;
        writes++;
      end
      #1;
`ifdef REGFILE_BYPASS_EN
      check("rand_busA", busA, (rs1_addr == 0) ? 32'h0 : nInt[rs1_addr]);
      check("rand_busB", busB, (rs2_addr == 0) ? 32'h0 : nInt[rs2_addr]);
      check("rand_fbusA", fbusA, nFp[frs1_addr]);
      check("rand_fbusB", fbusB, nFp[frs2_addr]);
`else
      check("rand_busA", busA, (rs1_addr == 0) ? 32'h0 : mInt[rs1_addr]);
      check("rand_busB", busB, (rs2_addr == 0) ? 32'h0 : mInt[rs2_addr]);
      check("rand_fbusA", fbusA, mFp[frs1_addr]);
      check("rand_fbusB", fbusB, mFp[frs2_addr]);
`endif
      check("rand_cnt", {16'b0, wr_count}, 32'(mCnt));
      @(posedge clk);
      mInt = nInt;
      mFp = nFp;
      mCnt = (mCnt + writes > 65535) ? 65535 : mCnt + writes;
    end
    @(negedge clk);
    idle();
    #1;
    check("rand_final_cnt", {16'b0, wr_count}, 32'(mCnt));

    // Counter saturation: 21844 triple writes reach 65532.
    asyncReset();
    @(negedge clk);
    rd_we = 1'b1; rd_addr = 1; rd_data = 32'h55; link_we = 1'b1; link_data = 32'h66;
    frd_we = 1'b1; frd_addr = 2; frd_data = 32'h77;
    repeat (21844) @(posedge clk);
    #1;
    check("sat_preload", {16'b0, wr_count}, 32'd65532);
    link_we = 1'b0; frd_we = 1'b0;
    @(posedge clk); #1;
    check("sat_single", {16'b0, wr_count}, 32'd65533);
    link_we = 1'b1; frd_we = 1'b1;
    @(posedge clk); #1;
    check("sat_clip", {16'b0, wr_count}, 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", {16'b0, wr_count}, 32'hFFFF);
    idle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
